// File: rtl/fetch.sv
// Instruction fetch stage: issues one-word reads to instruction memory and
// buffers returning words, tagged with their PC, in a 2-entry FIFO for decode.
module fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  // state | meaning
  // IDLE  | no requests issued
  // RUN   | issuing requests while FIFO space allows
  // REDIR | first cycle after redirect, memory data of this cycle is dropped
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_out;
  logic [1:0]        r_count;
  logic [15:0]       r_instr0;
  logic [15:0]       r_instr1;
  logic [ADDR_W-1:0] r_ipc0;
  logic [ADDR_W-1:0] r_ipc1;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic [2:0]        w_limit;

  assign w_pop  = instr_valid & instr_ready;
  assign w_push = r_out & ~redirect & (r_state != S_REDIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = en ? S_REDIR : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = en ? S_RUN : S_IDLE;
        S_RUN:   w_state_nxt = en ? S_RUN : S_IDLE;
        S_REDIR: w_state_nxt = en ? S_RUN : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Issue only if the word can be guaranteed a FIFO slot on arrival,
  // counting the word already in flight and the one leaving this cycle.
  always_comb begin
    w_occ    = {1'b0, r_count} + {2'b00, r_out};
    w_limit  = 3'd2 + {2'b00, w_pop};
    imem_req = 1'b0;
    if (!redirect && en && (r_state == S_RUN || r_state == S_REDIR) &&
        (w_occ < w_limit)) begin
      imem_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_out    <= 1'b0;
    end else begin
      r_out <= imem_req;
      if (redirect) begin
        r_pc <= redirect_pc;
      end else if (imem_req) begin
        r_pc     <= r_pc + PC_ONE;
        r_req_pc <= r_pc;
      end
    end
  end

  // Entry 0 is always the head; entry 1 only holds data when count is 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_instr0 <= '0;
      r_instr1 <= '0;
      r_ipc0   <= '0;
      r_ipc1   <= '0;
    end else if (redirect) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_instr0 <= imem_rdata;
            r_ipc0   <= r_req_pc;
          end else begin
            r_instr1 <= imem_rdata;
            r_ipc1   <= r_req_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_instr0 <= r_instr1;
          r_ipc0   <= r_ipc1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_instr0 <= imem_rdata;
            r_ipc0   <= r_req_pc;
          end else begin
            r_instr0 <= r_instr1;
            r_ipc0   <= r_ipc1;
            r_instr1 <= imem_rdata;
            r_ipc1   <= r_req_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr0;
  assign instr_pc    = r_ipc0;
  assign instr_valid = (r_count != 2'd0);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: per-cycle expected outputs from a table plus
// hand-written redirect, enable-drop, wrap-around and reset sequences.
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: word = address + 0x1000, one cycle after the request; junk otherwise
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr + 16'h1000;
    else          imem_rdata <= 16'hDEAD;
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic en_i, input logic rdy_i,
                      input logic red_i, input logic [15:0] rpc_i,
                      input logic e_req, input logic [15:0] e_addr,
                      input logic e_val, input logic [15:0] e_pc);
    logic [15:0] e_instr;
    en          = en_i;
    instr_ready = rdy_i;
    redirect    = red_i;
    redirect_pc = rpc_i;
    #1;
    check(tag, "imem_req", {31'd0, imem_req}, {31'd0, e_req});
    check(tag, "imem_addr", {16'd0, imem_addr}, {16'd0, e_addr});
    check(tag, "instr_valid", {31'd0, instr_valid}, {31'd0, e_val});
    if (e_val) begin
      e_instr = e_pc + 16'h1000;
      check(tag, "instr_pc", {16'd0, instr_pc}, {16'd0, e_pc});
      check(tag, "instr", {16'd0, instr}, {16'd0, e_instr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check(tag, "imem_req", {31'd0, imem_req}, 32'd0);
    check(tag, "instr_valid", {31'd0, instr_valid}, 32'd0);
    check(tag, "instr", {16'd0, instr}, 32'd0);
    check(tag, "instr_pc", {16'd0, instr_pc}, 32'd0);
    check(tag, "imem_addr", {16'd0, imem_addr}, 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    //             en    rdy   req   addr      valid pc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0003};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h0007, 1'b1, 16'h0005};

    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("idle", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0);

    for (int i = 0; i < 14; i++) begin
      step($sformatf("stream[%0d]", i), vecs[i].en, vecs[i].rdy, 1'b0, 16'h0,
           vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // redirect with one stale word queued and its successor in flight
    step("redir0", 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0008, 1'b1, 16'h0006);
    step("redir1", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0040, 1'b0, 16'h0);
    step("redir2", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0041, 1'b0, 16'h0);
    step("redir3", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0042, 1'b1, 16'h0040);
    step("redir4", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0043, 1'b1, 16'h0041);

    // enable dropped with a request outstanding: one more word, then idle
    step("endrop0", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0044, 1'b1, 16'h0042);
    step("endrop1", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0044, 1'b1, 16'h0043);
    step("endrop2", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0044, 1'b0, 16'h0);
    step("endrop3", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0044, 1'b0, 16'h0);
    step("endrop4", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0044, 1'b0, 16'h0);

    // PC wrap-around
    step("wrap0", 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0045, 1'b0, 16'h0);
    step("wrap1", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'hFFFE, 1'b0, 16'h0);
    step("wrap2", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'hFFFF, 1'b0, 16'h0);
    step("wrap3", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0000, 1'b1, 16'hFFFE);
    step("wrap4", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0001, 1'b1, 16'hFFFF);
    step("wrap5", 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0002, 1'b1, 16'h0000);

    // fill the FIFO, then reset mid-cycle
    step("fill0", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0003, 1'b1, 16'h0001);
    step("fill1", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0003, 1'b1, 16'h0001);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("restart0", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0);
    step("restart1", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 16'h0);
    step("restart2", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, 16'h0);
    step("restart3", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0002, 1'b1, 16'h0000);
    step("restart4", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b1, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
